display_scan_ctrl: RTL and testbench

- Drives a bank of multiplexed 7-segment digits on the board from one binary value.
- Converts a latched binary input to BCD sequentially, using shift-and-add-3 (double dabble), one bit per clock.
- Time-multiplexes the resulting digits through one shared instance of the team's BCD-to-7-segment decoder `Display`.
- Sits between processor-visible values (PC, ALU result, register readout) and the board's segment/anode pins.

---
 rtl/display_scan_ctrl_pkg.sv | 17 +
 rtl/display_scan_ctrl_display.sv | 24 ++
 rtl/display_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Holds FSM encoding, the blank digit code and width helpers.
package display_scan_ctrl_pkg;

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } estado_t;

  localparam logic [3:0] BLANK = 4'hF;

  // Counter width for values up to n-1, never narrower than 1 bit.
  function automatic int larg(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_display.sv
// BCD to 7-segment decoder, active-low {a,b,c,d,e,f,g}.
// Any non-decimal code, including the blank code, turns all segments off.
module Display (
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  always_comb begin
    case (digito)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Binary to BCD (double dabble, one bit per clock) feeding a
// time-multiplexed bank of 7-segment digits through one shared decoder.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_DIG     = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   valor,
  input  logic               carregar,
  input  logic               apaga_zeros,
  output logic               ocupado,
  output logic               estouro,
  output logic [6:0]         seg,
  output logic [NUM_DIG-1:0] an
);

  localparam int BW = 4 * NUM_DIG;
  localparam int CW = larg(WIDTH + 1);
  localparam int PW = larg(REFRESH_DIV);
  localparam int IW = larg(NUM_DIG);
  localparam logic [NUM_DIG-1:0] AN0 = ~NUM_DIG'(1);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_nx;
  logic [BW-1:0]    bcd_q, bcd_nx, adj;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, shout;
  logic [BW-1:0]    dig_q;
  logic             estouro_q;
  logic             fim;

  logic [PW-1:0]      pre_q;
  logic [IW-1:0]      idx_q;
  logic [6:0]         seg_q, dec;
  logic [NUM_DIG-1:0] an_q, blank;
  logic [3:0]         nib;
  logic               hi_zero;

  assign fim = (cnt_q == CW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= OCIOSO;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCIOSO:   if (carregar) state_d = CONVERTE;
      CONVERTE: if (fim)      state_d = OCIOSO;
      default:  state_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (state_q == CONVERTE);
  end

  // Add-3 on every nibble >= 5, then shift {bcd, bin} left once.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {shout, bcd_nx, bin_nx} = {adj, bin_q, 1'b0};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      dig_q     <= '0;
      estouro_q <= 1'b0;
    end else if (state_q == OCIOSO) begin
      if (carregar) begin
        bin_q <= valor;
        bcd_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= CW'(WIDTH);
      end
    end else begin
      bin_q <= bin_nx;
      bcd_q <= bcd_nx;
      ovf_q <= ovf_q | shout;
      cnt_q <= cnt_q - CW'(1);
      if (fim) begin
        dig_q     <= bcd_nx;
        estouro_q <= ovf_q | shout;
      end
    end
  end

  // Walk from the top digit down, tracking whether everything above is zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      hi_zero  = hi_zero && (dig_q[4*i +: 4] == 4'd0);
      blank[i] = estouro_q || (apaga_zeros && (i > 0) && hi_zero);
    end
  end

  always_comb begin
    nib = dig_q[4*int'(idx_q) +: 4];
    if (blank[idx_q]) nib = BLANK;
  end

  Display u_dec (
    .digito (nib),
    .seg    (dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= 7'b0000001;
      an_q  <= AN0;
    end else begin
      if (pre_q == PW'(REFRESH_DIV - 1)) begin
        pre_q <= '0;
        if (idx_q == IW'(NUM_DIG - 1)) idx_q <= '0;
        else                           idx_q <= idx_q + IW'(1);
      end else begin
        pre_q <= pre_q + PW'(1);
      end
      seg_q <= dec;
      an_q  <= ~(NUM_DIG'(1) << idx_q);
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign estouro = estouro_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a fast refresh divider.
// Expected segment codes are hand-derived from the decimal digits.
module tb_display_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] valor;
  logic        carregar;
  logic        apaga_zeros;
  logic        ocupado;
  logic        estouro;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;

  display_scan_ctrl #(
    .WIDTH       (16),
    .NUM_DIG     (4),
    .REFRESH_DIV (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valor       (valor),
    .carregar    (carregar),
    .apaga_zeros (apaga_zeros),
    .ocupado     (ocupado),
    .estouro     (estouro),
    .seg         (seg),
    .an          (an)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic read_dig(input int i, output logic [6:0] s);
    logic [3:0] want;
    bit found;
    want  = ~(4'b0001 << i);
    found = 0;
    s     = 'x;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      if (an == want) begin
        s     = seg;
        found = 1;
      end
    end
    if (!found) check($sformatf("scan_timeout_dig%0d", i), 32'(an), 32'(want));
  endtask

  task automatic check_digits(input string nm,
                              input logic [6:0] e0, e1, e2, e3);
    logic [6:0] s;
    logic [6:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      read_dig(i, s);
      check($sformatf("%s_dig%0d", nm, i), 32'(s), 32'(e[i]));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input int poke,
                         output int busy);
    @(negedge clock);
    valor    = v;
    carregar = 1'b1;
    @(negedge clock);
    carregar = 1'b0;
    busy = 0;
    while (ocupado && busy < 100) begin
      busy++;
      if (busy == poke) begin
        valor    = 16'd5678;
        carregar = 1'b1;
      end else begin
        carregar = 1'b0;
      end
      @(negedge clock);
    end
    carregar = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy;
    int n;
    reset_n     = 1'b0;
    valor       = '0;
    carregar    = 1'b0;
    apaga_zeros = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_an",  32'(an),      32'(4'b1110));
    check("rst_seg", 32'(seg),     32'(S0));
    check("rst_oc",  32'(ocupado), 32'(1'b0));
    check("rst_est", 32'(estouro), 32'(1'b0));
    reset_n = 1'b1;

    n = 0;
    while (an == 4'b1110 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("scan_step1", 32'(an), 32'(4'b1101));
    n = 0;
    while (an == 4'b1101 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("scan_period", 32'(n), 32'(4));
    check("scan_step2", 32'(an), 32'(4'b1011));
    repeat (4) @(negedge clock);
    check("scan_step3", 32'(an), 32'(4'b0111));
    repeat (4) @(negedge clock);
    check("scan_wrap", 32'(an), 32'(4'b1110));

    do_load(16'd1234, 0, busy);
    check("busy_1234", 32'(busy), 32'(16));
    check("est_1234", 32'(estouro), 32'(1'b0));
    check_digits("v1234", S4, S3, S2, S1);

    apaga_zeros = 1'b1;
    do_load(16'd7, 0, busy);
    check_digits("blank7", S7, SB, SB, SB);
    do_load(16'd0, 0, busy);
    check_digits("blank0", S0, SB, SB, SB);
    apaga_zeros = 1'b0;

    do_load(16'd12345, 0, busy);
    check("est_12345", 32'(estouro), 32'(1'b1));
    check_digits("ovf", SB, SB, SB, SB);
    do_load(16'd9999, 0, busy);
    check("est_9999", 32'(estouro), 32'(1'b0));
    check_digits("v9999", S9, S9, S9, S9);

    do_load(16'd1234, 5, busy);
    check("busy_poke", 32'(busy), 32'(16));
    check_digits("poke", S4, S3, S2, S1);

    @(negedge clock);
    valor    = 16'd1234;
    carregar = 1'b1;
    @(negedge clock);
    carregar = 1'b0;
    repeat (7) @(negedge clock);
    check("mid_busy", 32'(ocupado), 32'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_oc",  32'(ocupado), 32'(1'b0));
    check("mid_an",  32'(an),      32'(4'b1110));
    check("mid_seg", 32'(seg),     32'(S0));
    check("mid_est", 32'(estouro), 32'(1'b0));
    @(negedge clock);
    reset_n = 1'b1;

    do_load(16'd42, 0, busy);
    check("busy_42", 32'(busy), 32'(16));
    check_digits("v42", S2, S4, S0, S0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
